// File: rtl/timer_countdown_core.sv
// Countdown engine for the timer: loads six clamped BCD set-point digits from the editor,
// counts them down at one tick per CLK_HZ cycles, and holds an alarm for ALARM_SEC ticks.
module timer_countdown_core #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int ALARM_SEC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       btn,
  input  logic       start_stop,
  input  logic       clear,
  input  logic [3:0] n_sec0,
  input  logic [3:0] n_sec1,
  input  logic [3:0] n_min0,
  input  logic [3:0] n_min1,
  input  logic [3:0] n_hrs0,
  input  logic [3:0] n_hrs1,
  output logic [3:0] t_sec0,
  output logic [3:0] t_sec1,
  output logic [3:0] t_min0,
  output logic [3:0] t_min1,
  output logic [3:0] t_hrs0,
  output logic [3:0] t_hrs1,
  output logic       running,
  output logic       alarm,
  output logic       done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EDIT  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    ALARM = 3'd4
  } state_t;

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int AW = (ALARM_SEC > 0) ? $clog2(ALARM_SEC + 1) : 1;
  // Index 0 is sec0 ... index 5 is hrs1.
  localparam logic [5:0][3:0] DIGIT_MAX = {4'd2, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9};

  state_t               state_q, state_d;
  logic [5:0][3:0]      t_q, t_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [AW-1:0]        alarm_cnt_q, alarm_cnt_d;
  logic                 running_q, running_d;
  logic                 alarm_q, alarm_d;
  logic                 done_q, done_d;

  logic [5:0][3:0]      n_in;
  logic [5:0][3:0]      n_clamped;
  logic [5:0][3:0]      t_dec;
  logic [5:0]           borrow;
  logic                 tick;
  logic                 edit_req;

  assign n_in     = {n_hrs1, n_hrs0, n_min1, n_min0, n_sec1, n_sec0};
  assign edit_req = a && btn;
  assign tick     = ((state_q == RUN) || (state_q == ALARM)) && (presc_q == PW'(CLK_HZ - 1));
  assign borrow[0] = 1'b1;

  // Per-digit clamp and ripple-borrow decrement; a zero digit that borrows wraps to its max.
  for (genvar gi = 0; gi < 6; gi++) begin : g_digit
    assign n_clamped[gi] = (n_in[gi] > DIGIT_MAX[gi]) ? DIGIT_MAX[gi] : n_in[gi];
    assign t_dec[gi]     = !borrow[gi]      ? t_q[gi] :
                           (t_q[gi] == 4'd0) ? DIGIT_MAX[gi] : t_q[gi] - 4'd1;
    if (gi < 5) begin : g_borrow
      assign borrow[gi+1] = borrow[gi] && (t_q[gi] == 4'd0);
    end
  end

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    presc_d     = presc_q;
    alarm_cnt_d = alarm_cnt_q;
    done_d      = 1'b0;

    if ((state_q == RUN) || (state_q == ALARM)) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (clear) begin
          t_d = '0;
        end else if (edit_req) begin
          state_d = EDIT;
        end else if (start_stop && (t_q != '0)) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      EDIT: begin
        t_d = n_clamped;
        if (!edit_req) state_d = IDLE;
      end
      RUN: begin
        if (clear) begin
          state_d = IDLE;
          t_d     = '0;
        end else if (start_stop) begin
          state_d = PAUSE;
          presc_d = presc_q;
        end else if (tick) begin
          t_d = t_dec;
          if (t_dec == '0) begin
            state_d     = ALARM;
            done_d      = 1'b1;
            alarm_cnt_d = '0;
          end
        end
      end
      PAUSE: begin
        if (clear) begin
          state_d = IDLE;
          t_d     = '0;
        end else if (edit_req) begin
          state_d = EDIT;
        end else if (start_stop) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      ALARM: begin
        if (clear) begin
          state_d = IDLE;
          t_d     = '0;
        end else if (edit_req) begin
          state_d = EDIT;
        end else if (start_stop) begin
          state_d = IDLE;
        end else if (tick) begin
          alarm_cnt_d = alarm_cnt_q + AW'(1);
          if (alarm_cnt_d == AW'(ALARM_SEC)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Prescaler only matters in RUN/ALARM; park it at zero elsewhere except the PAUSE freeze.
    if ((state_d == IDLE) || (state_d == EDIT)) presc_d = '0;

    running_d = (state_d == RUN);
    alarm_d   = (state_d == ALARM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      t_q         <= '0;
      presc_q     <= '0;
      alarm_cnt_q <= '0;
      running_q   <= 1'b0;
      alarm_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      presc_q     <= presc_d;
      alarm_cnt_q <= alarm_cnt_d;
      running_q   <= running_d;
      alarm_q     <= alarm_d;
      done_q      <= done_d;
    end
  end

  assign {t_hrs1, t_hrs0, t_min1, t_min0, t_sec1, t_sec0} = t_q;
  assign running = running_q;
  assign alarm   = alarm_q;
  assign done    = done_q;
  assign state   = state_q;

endmodule

// File: tb/tb_timer_countdown_core.sv
// Scenario bench for timer_countdown_core with CLK_HZ=4 and ALARM_SEC=3; expected digit
// updates are queued at stimulus time and popped when the live count changes.
module tb_timer_countdown_core;

  localparam int CLK_HZ    = 4;
  localparam int ALARM_SEC = 3;
  localparam logic [2:0] S_IDLE = 3'd0, S_EDIT = 3'd1, S_RUN = 3'd2, S_PAUSE = 3'd3, S_ALARM = 3'd4;

  logic       clk, rst, a, btn, start_stop, clear;
  logic [3:0] n_sec0, n_sec1, n_min0, n_min1, n_hrs0, n_hrs1;
  logic [3:0] t_sec0, t_sec1, t_min0, t_min1, t_hrs0, t_hrs1;
  logic       running, alarm, done;
  logic [2:0] state;
  logic [23:0] t_all;

  typedef struct packed {
    logic [23:0] t;
    logic [2:0]  st;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  timer_countdown_core #(.CLK_HZ(CLK_HZ), .ALARM_SEC(ALARM_SEC)) dut (
    .clk(clk), .rst(rst), .a(a), .btn(btn), .start_stop(start_stop), .clear(clear),
    .n_sec0(n_sec0), .n_sec1(n_sec1), .n_min0(n_min0), .n_min1(n_min1),
    .n_hrs0(n_hrs0), .n_hrs1(n_hrs1),
    .t_sec0(t_sec0), .t_sec1(t_sec1), .t_min0(t_min0), .t_min1(t_min1),
    .t_hrs0(t_hrs0), .t_hrs1(t_hrs1),
    .running(running), .alarm(alarm), .done(done), .state(state)
  );

  assign t_all = {t_hrs1, t_hrs0, t_min1, t_min0, t_sec1, t_sec0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_stop = 1'b1; step(); start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic load(input logic [23:0] v);
    {n_hrs1, n_hrs0, n_min1, n_min0, n_sec1, n_sec0} = v;
    a = 1'b1; btn = 1'b1;
    step(); step();
    a = 1'b0; btn = 1'b0;
    step();
  endtask

  task automatic expect_next(input int exp_cycles, input string name);
    logic [23:0] prev;
    int n;
    exp_t e;
    prev = t_all;
    n = 0;
    while (t_all === prev && n < 40) begin step(); n++; end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: count changed to %h but no expectation queued", name, t_all);
    end else begin
      e = sb.pop_front();
      if (t_all !== e.t || state !== e.st) begin
        errors++;
        $display("FAIL %s: got t=%h state=%0d, expected t=%h state=%0d", name, t_all, state, e.t, e.st);
      end
    end
    checks++;
    if (n !== exp_cycles) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, expected %0d", name, n, exp_cycles);
    end
    $display("txn %s: t=%h state=%0d after %0d cycles", name, t_all, state, n);
  endtask

  task automatic test_reset();
    rst = 1'b1; a = 0; btn = 0; start_stop = 0; clear = 0;
    {n_hrs1, n_hrs0, n_min1, n_min0, n_sec1, n_sec0} = '0;
    step(); step();
    checks++;
    if ({t_all, state, running, alarm, done} !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs: got t=%h state=%0d run=%b alm=%b done=%b, expected all 0",
               t_all, state, running, alarm, done);
    end
    rst = 1'b0;
    step();
    checks++;
    if (state !== S_IDLE) begin
      errors++; $display("FAIL reset_idle: got state=%0d, expected %0d", state, S_IDLE);
    end
    $display("txn reset: state=%0d t=%h", state, t_all);
  endtask

  task automatic test_countdown();
    load(24'h000003);
    checks++;
    if (t_all !== 24'h000003 || state !== S_IDLE) begin
      errors++; $display("FAIL load_3: got t=%h state=%0d, expected t=000003 state=0", t_all, state);
    end
    pulse_start();
    checks++;
    if (state !== S_RUN || running !== 1'b1) begin
      errors++; $display("FAIL start_run: got state=%0d running=%b, expected state=2 running=1", state, running);
    end
    sb.push_back('{24'h000002, S_RUN});
    sb.push_back('{24'h000001, S_RUN});
    sb.push_back('{24'h000000, S_ALARM});
    expect_next(4, "cd_2");
    expect_next(4, "cd_1");
    expect_next(4, "cd_0");
    checks++;
    if (done !== 1'b1 || alarm !== 1'b1 || running !== 1'b0) begin
      errors++; $display("FAIL cd_done: got done=%b alarm=%b running=%b, expected 1 1 0", done, alarm, running);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL cd_done_pulse: got done=%b one cycle later, expected 0", done);
    end
    pulse_clear();
  endtask

  task automatic test_borrow();
    load(24'h010000);
    pulse_start();
    sb.push_back('{24'h005959, S_RUN});
    expect_next(4, "borrow_hrs");
    pulse_clear();
    load(24'h001000);
    pulse_start();
    sb.push_back('{24'h000959, S_RUN});
    expect_next(4, "borrow_min1");
    pulse_clear();
  endtask

  task automatic test_pause();
    load(24'h000005);
    pulse_start();
    sb.push_back('{24'h000004, S_RUN});
    sb.push_back('{24'h000003, S_RUN});
    expect_next(4, "pause_4");
    expect_next(4, "pause_3");
    pulse_start();
    checks++;
    if (state !== S_PAUSE || running !== 1'b0) begin
      errors++; $display("FAIL pause_enter: got state=%0d running=%b, expected state=3 running=0", state, running);
    end
    repeat (20) step();
    checks++;
    if (t_all !== 24'h000003 || state !== S_PAUSE) begin
      errors++; $display("FAIL pause_hold: got t=%h state=%0d, expected t=000003 state=3", t_all, state);
    end
    pulse_start();
    sb.push_back('{24'h000002, S_RUN});
    expect_next(4, "resume_2");
    pulse_clear();
  endtask

  task automatic test_idle_zero_clamp();
    pulse_start();
    checks++;
    if (state !== S_IDLE || running !== 1'b0) begin
      errors++; $display("FAIL zero_start: got state=%0d running=%b, expected state=0 running=0", state, running);
    end
    load(24'h9B0C70);
    checks++;
    if (t_all !== 24'h290950) begin
      errors++; $display("FAIL clamp: got t=%h, expected 290950", t_all);
    end
    $display("txn clamp: t=%h", t_all);
  endtask

  task automatic test_clear_priority();
    load(24'h000010);
    pulse_start();
    a = 1'b1; btn = 1'b1;
    step(); step();
    a = 1'b0; btn = 1'b0;
    checks++;
    if (state !== S_RUN || t_all !== 24'h000010) begin
      errors++; $display("FAIL run_edit_ignored: got t=%h state=%0d, expected t=000010 state=2", t_all, state);
    end
    step();
    clear = 1'b1; start_stop = 1'b1;
    step();
    clear = 1'b0; start_stop = 1'b0;
    checks++;
    if (state !== S_IDLE || t_all !== 24'h0 || running !== 1'b0) begin
      errors++; $display("FAIL clear_wins: got t=%h state=%0d running=%b, expected t=000000 state=0 running=0",
                         t_all, state, running);
    end
    load(24'h000002);
    pulse_start();
    sb.push_back('{24'h000001, S_RUN});
    expect_next(4, "post_clear_presc");
    pulse_clear();
  endtask

  task automatic test_alarm_timeout();
    int n;
    load(24'h000001);
    pulse_start();
    sb.push_back('{24'h000000, S_ALARM});
    expect_next(4, "alarm_enter");
    n = 0;
    while (state === S_ALARM && alarm === 1'b1 && n < 40) begin step(); n++; end
    checks++;
    if (n !== 4 * ALARM_SEC || state !== S_IDLE || alarm !== 1'b0) begin
      errors++; $display("FAIL alarm_timeout: got %0d cycles state=%0d alarm=%b, expected %0d cycles state=0 alarm=0",
                         n, state, alarm, 4 * ALARM_SEC);
    end
    $display("txn alarm_timeout: %0d cycles", n);

    load(24'h000002);
    pulse_start();
    sb.push_back('{24'h000001, S_RUN});
    expect_next(4, "rst_run_pre");
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({t_all, state, running, alarm, done} !== 30'd0) begin
      errors++; $display("FAIL rst_mid_run: got t=%h state=%0d run=%b, expected all 0", t_all, state, running);
    end
    #1 rst = 1'b0;
    step();

    load(24'h000001);
    pulse_start();
    sb.push_back('{24'h000000, S_ALARM});
    expect_next(4, "rst_alarm_pre");
    step(); step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({t_all, state, running, alarm, done} !== 30'd0) begin
      errors++; $display("FAIL rst_mid_alarm: got state=%0d alarm=%b, expected all 0", state, alarm);
    end
    #1 rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_borrow();
    test_pause();
    test_idle_zero_clamp();
    test_clear_priority();
    test_alarm_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
